lsu_handshake: RTL and testbench
================================

Name: lsu_handshake

Overview:
- Multi-cycle load/store unit that replaces the combinational dmem port of the single-cycle hart with a realistic request/response memory interface.
- Sits between the execute stage and data memory.
- Generates the byte mask and aligned address, lane-shifts store data, and shifts plus sign/zero-extends load data.
- Detects misaligned accesses, and bounds memory latency with a timeout.

Parameters:
- TIMEOUT_CYCLES, 256, cycles allowed in REQ+WAIT before a timeout trap; 0 disables the timeout.
- CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  core presents an access this cycle
- o_ready  out  1  unit idle; access accepted when i_valid & o_ready at rising edge
- i_is_load  in  1  access is a load
- i_is_store  in  1  access is a store
- i_size  in  2  00 byte, 01 half, 10 word; 11 illegal
- i_unsigned  in  1  zero-extend load (lbu/lhu)
- i_addr  in  32  byte address (ALU result)
- i_wdata  in  32  store data, r[rs2], unshifted
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  32  extended load result, valid with o_done
- o_trap  out  1  access trapped (misalign, illegal size, both load and store, timeout), valid with o_done
- o_timeout  out  1  trap cause was timeout, valid with o_done
- o_mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- o_mem_ren  out  1  read request
- o_mem_wen  out  1  write request; never asserted together with o_mem_ren
- o_mem_wdata  out  32  store data shifted to its byte lane
- o_mem_mask  out  4  byte enables
- i_mem_ready  in  1  memory accepts the request this edge
- i_mem_valid  in  1  load data valid this cycle
- i_mem_rdata  in  32  load data word

Behaviour:
- Reset: state IDLE; o_ready=1; o_done, o_trap, o_timeout, o_mem_ren, o_mem_wen = 0; o_rdata, o_mem_addr, o_mem_wdata = 0; o_mem_mask = 0; counter = 0.
- Reset mid-operation: abort to IDLE and issue no write. A late i_mem_valid is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE. Only IDLE asserts o_ready.
- IDLE:
  - On i_valid with exactly one of load/store: latch addr, size, unsigned and wdata.
  - Go to DONE with trap if any of: size=11; half with addr[0]=1; word with addr[1:0]≠00. No memory request is issued.
  - Otherwise go to REQ.
  - i_valid with both load and store: DONE with trap.
  - i_valid with neither: ignored; stay IDLE.
- Mask, using offset o=addr[1:0]:
  - byte: 4'b0001<<o
  - half: o[1]=0 gives 0011, o[1]=1 gives 1100
  - word: 1111
- Store data: o_mem_wdata = i_wdata<<(8*o). Unmasked lanes are don't-care.
- REQ:
  - Assert ren (load) or wen (store). Hold addr, mask and wdata stable until i_mem_ready=1 at an edge.
  - Store accepted: go to DONE.
  - Load accepted: go to WAIT.
- WAIT:
  - ren/wen deasserted.
  - On i_mem_valid: compute rdata = i_mem_rdata>>(8*o).
  - Byte: bits [7:0], sign- or zero-extended per unsigned. Half: bits [15:0], extended likewise. Word: unchanged.
  - Register the result and go to DONE.
  - i_mem_valid in the same cycle as acceptance in REQ is not used; data is only sampled in WAIT.
- DONE: o_done=1 for exactly one cycle with o_rdata/o_trap/o_timeout registered, then go to IDLE. o_rdata=0 for stores and traps.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without progress, go to DONE with o_trap=1 and o_timeout=1, and drop ren/wen.
  - Progress (ready in REQ, valid in WAIT) on the same edge wins over timeout.
- Latency with zero-wait memory:
  - Store: accept at edge 0, o_done high during cycle 2.
  - Load with i_mem_valid during WAIT cycle: o_done high during cycle 3.
  - Misalign trap: o_done high during cycle 1.
- Back-to-back: new access accepted in the cycle after DONE (IDLE); no overlap.

Test Plan:
- sb: addr=0x00002003, wdata=0x000000AB, mem ready=1 → o_mem_addr=0x00002000, mask=1000, wdata[31:24]=0xAB, wen one cycle, o_done 2 cycles after accept, trap=0.
- lh at 0x00001002, i_mem_rdata=0x8001xxxx: signed → o_rdata=0xFFFF8001; lhu → 0x00008001; mask=1100.
- lb at 0x00000001, rdata=0x00007F00 → o_rdata=0x0000007F. lbu at the same address with rdata=0x0000FF00 → 0x000000FF.
- Misalign: lw at 0x00000006 and lh at 0x00000003 → no ren/wen ever asserted, o_done next cycle with o_trap=1, o_timeout=0.
- Backpressure and timeout: lw with i_mem_ready held 0 for 5 cycles, then 1, then valid 3 cycles later → ren and address stable throughout, correct data. TIMEOUT_CYCLES=4 with ready never asserted → o_done with trap=1, timeout=1 after 4 cycles in REQ.
- Reset asserted in WAIT, then i_mem_valid=1 after reset → no o_done, o_ready=1, all outputs at reset values.

Source files
------------

// File: rtl/lsu_handshake.sv
// Multi-cycle load/store unit: request/response memory port with byte lanes,
// load extension, misalignment traps and a bounded wait for memory.
module lsu_handshake #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_trap,
    output logic        o_timeout,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 32'd0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               is_load_q, is_load_n;
    logic [1:0]         size_q, size_n;
    logic               uns_q, uns_n;
    logic [1:0]         off_q, off_n;
    logic               ready_n, done_n, trap_n, timeout_n, ren_n, wen_n;
    logic [31:0]        rdata_n, addr_n, wdata_n;
    logic [3:0]         mask_n;
    logic               misalign_c, to_hit_c;
    logic [31:0]        shifted_c, load_ext_c;

    // Byte enables for an access of the given size at byte offset off.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    assign misalign_c = (i_size == 2'b11)
                      | ((i_size == 2'b01) & i_addr[0])
                      | ((i_size == 2'b10) & (|i_addr[1:0]));
    assign to_hit_c   = TO_EN && (cnt_q == CNT_LAST);

    // Align the returned word to bit 0 and extend to the access size.
    always_comb begin
        shifted_c = i_mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_ext_c = {{24{~uns_q & shifted_c[7]}}, shifted_c[7:0]};
            2'b01:   load_ext_c = {{16{~uns_q & shifted_c[15]}}, shifted_c[15:0]};
            default: load_ext_c = shifted_c;
        endcase
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        is_load_n = is_load_q;
        size_n    = size_q;
        uns_n     = uns_q;
        off_n     = off_q;
        addr_n    = o_mem_addr;
        mask_n    = o_mem_mask;
        wdata_n   = o_mem_wdata;
        rdata_n   = '0;
        trap_n    = 1'b0;
        timeout_n = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (i_is_load & i_is_store) begin
                        state_n = S_DONE;
                        trap_n  = 1'b1;
                    end else if (i_is_load | i_is_store) begin
                        is_load_n = i_is_load;
                        size_n    = i_size;
                        uns_n     = i_unsigned;
                        off_n     = i_addr[1:0];
                        if (misalign_c) begin
                            state_n = S_DONE;
                            trap_n  = 1'b1;
                        end else begin
                            state_n = S_REQ;
                            cnt_n   = '0;
                            addr_n  = {i_addr[31:2], 2'b00};
                            mask_n  = lane_mask(i_size, i_addr[1:0]);
                            wdata_n = i_wdata << {i_addr[1:0], 3'b000};
                        end
                    end
                end
            end
            S_REQ: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (i_mem_ready) begin
                    state_n = is_load_q ? S_WAIT : S_DONE;
                end else if (to_hit_c) begin
                    state_n   = S_DONE;
                    trap_n    = 1'b1;
                    timeout_n = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (i_mem_valid) begin
                    state_n = S_DONE;
                    rdata_n = load_ext_c;
                end else if (to_hit_c) begin
                    state_n   = S_DONE;
                    trap_n    = 1'b1;
                    timeout_n = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Handshake outputs are a function of the state being entered.
        ready_n = (state_n == S_IDLE);
        done_n  = (state_n == S_DONE);
        ren_n   = (state_n == S_REQ) &  is_load_n;
        wen_n   = (state_n == S_REQ) & ~is_load_n;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_load_q   <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            o_ready     <= 1'b1;
            o_done      <= 1'b0;
            o_rdata     <= '0;
            o_trap      <= 1'b0;
            o_timeout   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_ren   <= 1'b0;
            o_mem_wen   <= 1'b0;
            o_mem_wdata <= '0;
            o_mem_mask  <= '0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            is_load_q   <= is_load_n;
            size_q      <= size_n;
            uns_q       <= uns_n;
            off_q       <= off_n;
            o_ready     <= ready_n;
            o_done      <= done_n;
            o_rdata     <= rdata_n;
            o_trap      <= trap_n;
            o_timeout   <= timeout_n;
            o_mem_addr  <= addr_n;
            o_mem_ren   <= ren_n;
            o_mem_wen   <= wen_n;
            o_mem_wdata <= wdata_n;
            o_mem_mask  <= mask_n;
        end
    end

endmodule

// File: tb/tb_lsu_handshake.sv
// Scoreboard bench for lsu_handshake: default-timeout unit for data paths and
// handshakes, a TIMEOUT_CYCLES=4 unit for the timeout trap.
module tb_lsu_handshake;

    logic        i_clk, i_rst;
    logic        i_valid, i_valid2;
    logic        i_is_load, i_is_store, i_unsigned;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_wdata;
    logic        i_mem_ready, i_mem_valid;
    logic [31:0] i_mem_rdata;

    logic        o_ready, o_done, o_trap, o_timeout, o_mem_ren, o_mem_wen;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;

    logic        o2_ready, o2_done, o2_trap, o2_timeout, o2_mem_ren, o2_mem_wen;
    logic [31:0] o2_rdata, o2_mem_addr, o2_mem_wdata;
    logic [3:0]  o2_mem_mask;

    typedef struct packed {
        logic [31:0] rdata;
        logic        trap;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp2_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    lsu_handshake dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_done(o_done), .o_rdata(o_rdata), .o_trap(o_trap), .o_timeout(o_timeout),
        .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata)
    );

    lsu_handshake #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut_to (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid2), .o_ready(o2_ready),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_done(o2_done), .o_rdata(o2_rdata), .o_trap(o2_trap), .o_timeout(o2_timeout),
        .o_mem_addr(o2_mem_addr), .o_mem_ren(o2_mem_ren), .o_mem_wen(o2_mem_wen),
        .o_mem_wdata(o2_mem_wdata), .o_mem_mask(o2_mem_mask),
        .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_mask(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0: case (off)
                2'd0: exp_mask = 4'b0001;
                2'd1: exp_mask = 4'b0010;
                2'd2: exp_mask = 4'b0100;
                default: exp_mask = 4'b1000;
            endcase
            2'd1:    exp_mask = off[1] ? 4'b1100 : 4'b0011;
            default: exp_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] bits_of(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic [31:0] load_model(input logic [1:0] sz, input logic uns,
                                               input logic [1:0] off, input logic [31:0] word);
        int          o;
        int          hi;
        logic [7:0]  b;
        logic [15:0] h;
        o  = int'(off);
        hi = int'(off[1]);
        b  = word[8*o +: 8];
        h  = word[16*hi +: 16];
        case (sz)
            2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Completion monitors: every o_done pops one expected result.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst) begin
            chk("ren_wen_excl", 32'(o_mem_ren & o_mem_wen), 32'd0);
            if (o_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(o_done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", o_rdata, e.rdata);
                    chk("trap", 32'(o_trap), 32'(e.trap));
                    chk("timeout", 32'(o_timeout), 32'(e.timeout));
                end
            end
            if (o2_done) begin
                if (exp2_q.size() == 0) begin
                    chk("unexpected_done2", 32'(o2_done), 32'd0);
                end else begin
                    e = exp2_q.pop_front();
                    chk("rdata2", o2_rdata, e.rdata);
                    chk("trap2", 32'(o2_trap), 32'(e.trap));
                    chk("timeout2", 32'(o2_timeout), 32'(e.timeout));
                end
            end
        end
    end

    task automatic wait_ready();
        int w = 0;
        while (!o_ready && w < 20) begin
            @(posedge i_clk); #1;
            w++;
        end
        chk("ready_before_access", 32'(o_ready), 32'd1);
    endtask

    // One access on the main unit; memory accepts after rdy_dly stall cycles
    // and returns data vld_dly cycles into WAIT.
    task automatic run_access(input logic ld, input logic st, input logic [1:0] sz,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] word, input int rdy_dly, input int vld_dly,
                              input logic exp_trap, input logic [31:0] exp_rdata);
        exp_t        e;
        logic [31:0] bm;
        logic [31:0] exp_wd;
        wait_ready();
        e.rdata = exp_rdata; e.trap = exp_trap; e.timeout = 1'b0;
        exp_q.push_back(e);
        i_valid = 1'b1; i_is_load = ld; i_is_store = st; i_size = sz;
        i_unsigned = uns; i_addr = addr; i_wdata = wdata;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        if (exp_trap) begin
            @(negedge i_clk);
            chk("trap_done_latency", 32'(o_done), 32'd1);
            chk("trap_no_ren", 32'(o_mem_ren), 32'd0);
            chk("trap_no_wen", 32'(o_mem_wen), 32'd0);
            @(posedge i_clk); #1;
            return;
        end
        bm = bits_of(exp_mask(sz, addr[1:0]));
        case (sz)
            2'd0:    exp_wd = {4{wdata[7:0]}};
            2'd1:    exp_wd = {2{wdata[15:0]}};
            default: exp_wd = wdata;
        endcase
        for (int k = 0; k <= rdy_dly; k++) begin
            if (k == rdy_dly) begin
                i_mem_ready = 1'b1;
                // Data alongside acceptance must be ignored.
                i_mem_valid = ld;
                i_mem_rdata = ~word;
            end
            @(negedge i_clk);
            chk("req_ren", 32'(o_mem_ren), 32'(ld));
            chk("req_wen", 32'(o_mem_wen), 32'(st));
            chk("req_addr", o_mem_addr, {addr[31:2], 2'b00});
            chk("req_mask", 32'(o_mem_mask), 32'(exp_mask(sz, addr[1:0])));
            chk("req_wdata", o_mem_wdata & bm, exp_wd & bm);
            @(posedge i_clk); #1;
        end
        i_mem_ready = 1'b0;
        i_mem_valid = 1'b0;
        if (ld) begin
            for (int k = 0; k <= vld_dly; k++) begin
                if (k == vld_dly) begin
                    i_mem_valid = 1'b1;
                    i_mem_rdata = word;
                end
                @(negedge i_clk);
                chk("wait_ren_low", 32'(o_mem_ren), 32'd0);
                chk("wait_no_done", 32'(o_done), 32'd0);
                @(posedge i_clk); #1;
            end
            i_mem_valid = 1'b0;
            i_mem_rdata = 32'hDEADBEEF;
        end
        @(negedge i_clk);
        chk("done_pulse", 32'(o_done), 32'd1);
        chk("done_wen_low", 32'(o_mem_wen), 32'd0);
        @(posedge i_clk); #1;
        chk("done_one_cycle", 32'(o_done), 32'd0);
    endtask

    initial begin
        logic        ld;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a, wd, wo;

        i_rst = 1'b1; i_valid = 1'b0; i_valid2 = 1'b0;
        i_is_load = 1'b0; i_is_store = 1'b0; i_size = 2'b00; i_unsigned = 1'b0;
        i_addr = '0; i_wdata = '0;
        i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = '0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;

        @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_ren", 32'(o_mem_ren), 32'd0);
        chk("rst_wen", 32'(o_mem_wen), 32'd0);
        chk("rst_addr", o_mem_addr, 32'd0);
        chk("rst_mask", 32'(o_mem_mask), 32'd0);
        chk("rst_wdata", o_mem_wdata, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        @(posedge i_clk); #1;

        // Directed cases
        run_access(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_2003, 32'h0000_00AB, 32'h0, 0, 0, 1'b0, 32'h0);
        run_access(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_1002, 32'h0, 32'h8001_5A5A, 0, 0, 1'b0, 32'hFFFF_8001);
        run_access(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'h0, 32'h8001_5A5A, 0, 0, 1'b0, 32'h0000_8001);
        run_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_7F00, 0, 0, 1'b0, 32'h0000_007F);
        run_access(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'h0, 32'h0000_FF00, 0, 0, 1'b0, 32'h0000_00FF);
        run_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_FF00, 0, 0, 1'b0, 32'hFFFF_FFFF);
        run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0);
        run_access(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0);
        run_access(1'b0, 1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0);
        run_access(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0);
        run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 5, 3, 1'b0, 32'hCAFE_F00D);
        run_access(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0302, 32'h1234_BEEF, 32'h0, 2, 0, 1'b0, 32'h0);

        // Valid with neither load nor store is ignored
        i_valid = 1'b1; i_is_load = 1'b0; i_is_store = 1'b0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("neither_ready", 32'(o_ready), 32'd1);
        chk("neither_ren", 32'(o_mem_ren), 32'd0);
        chk("neither_wen", 32'(o_mem_wen), 32'd0);
        @(posedge i_clk); #1;

        // Random aligned traffic with random memory latencies
        for (int n = 0; n < 40; n++) begin
            ld  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 2));
            uns = 1'($urandom_range(0, 1));
            a   = $urandom;
            wd  = $urandom;
            wo  = $urandom;
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
            run_access(ld, ~ld, sz, uns, a, wd, wo,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0,
                       ld ? load_model(sz, uns, a[1:0], wo) : 32'h0);
        end

        // Timeout on the short-timeout unit: memory never accepts
        begin
            exp_t e;
            e.rdata = '0; e.trap = 1'b1; e.timeout = 1'b1;
            exp2_q.push_back(e);
        end
        i_valid2 = 1'b1; i_is_load = 1'b1; i_is_store = 1'b0; i_size = 2'd2; i_addr = 32'h0000_0100;
        @(posedge i_clk); #1;
        i_valid2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("to_req_ren", 32'(o2_mem_ren), 32'd1);
            chk("to_no_done", 32'(o2_done), 32'd0);
            @(posedge i_clk); #1;
        end
        @(negedge i_clk);
        chk("to_done", 32'(o2_done), 32'd1);
        chk("to_ren_drop", 32'(o2_mem_ren), 32'd0);
        @(posedge i_clk); #1;

        // Reset during WAIT, then a stale response
        wait_ready();
        i_valid = 1'b1; i_is_load = 1'b1; i_is_store = 1'b0; i_size = 2'd2; i_addr = 32'h0000_0040;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_mem_ready = 1'b1;
        @(posedge i_clk); #1;
        i_mem_ready = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 32'h1234_5678;
        @(posedge i_clk); #1;
        i_mem_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("rstw_no_done", 32'(o_done), 32'd0);
            chk("rstw_ready", 32'(o_ready), 32'd1);
            chk("rstw_ren", 32'(o_mem_ren), 32'd0);
            chk("rstw_addr", o_mem_addr, 32'd0);
            chk("rstw_mask", 32'(o_mem_mask), 32'd0);
            chk("rstw_rdata", o_rdata, 32'd0);
            chk("rstw_trap", 32'(o_trap), 32'd0);
            @(posedge i_clk); #1;
        end

        // Reset during a stalled store request drops the write
        i_valid = 1'b1; i_is_load = 1'b0; i_is_store = 1'b1; i_size = 2'd2;
        i_addr = 32'h0000_0080; i_wdata = 32'h5555_AAAA;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("rsts_wen_before", 32'(o_mem_wen), 32'd1);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rsts_wen_after", 32'(o_mem_wen), 32'd0);
        chk("rsts_ready", 32'(o_ready), 32'd1);
        chk("rsts_wdata", o_mem_wdata, 32'd0);
        repeat (2) @(posedge i_clk);
        #1;

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("sb2_empty", 32'(exp2_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
